// File: rtl/rawdns_pkg.sv
// Shared types and default geometry for the RAWDNS denoise pipeline blocks.
package rawdns_pkg;

  localparam int DATA_WIDTH_DEF   = 16;
  localparam int WEIGHT_WIDTH_DEF = 8;
  localparam int SUM_WIDTH_DEF    = 32;
  localparam int TAPS_DEF         = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } sched_state_t;

  // Counter width for a tap index 0..taps-1; never narrower than one bit.
  function automatic int cnt_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/nlm_mac.sv
// Registered multiply-accumulate pair: weighted pixel sum and weight sum.
module nlm_mac
  import rawdns_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int SUM_WIDTH    = SUM_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clear,
  input  logic                    i_en,
  input  logic                    i_load,
  input  logic [WEIGHT_WIDTH-1:0] i_weight,
  input  logic [DATA_WIDTH-1:0]   i_pix,
  output logic [SUM_WIDTH-1:0]    o_pix_sum,
  output logic [SUM_WIDTH-1:0]    o_weight_sum
);

  localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;

  logic [PROD_W-1:0]    w_prod;
  logic [SUM_WIDTH-1:0] w_prod_ext;
  logic [SUM_WIDTH-1:0] w_weight_ext;
  logic [SUM_WIDTH-1:0] r_pix_sum;
  logic [SUM_WIDTH-1:0] r_weight_sum;

  assign w_prod       = PROD_W'(i_weight) * PROD_W'(i_pix);
  assign w_prod_ext   = SUM_WIDTH'(w_prod);
  assign w_weight_ext = SUM_WIDTH'(i_weight);

  // Load overwrites instead of adding, so a window needs no separate clear cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_sum    <= '0;
      r_weight_sum <= '0;
    end else if (i_clear) begin
      r_pix_sum    <= '0;
      r_weight_sum <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_pix_sum    <= w_prod_ext;
        r_weight_sum <= w_weight_ext;
      end else begin
        r_pix_sum    <= r_pix_sum + w_prod_ext;
        r_weight_sum <= r_weight_sum + w_weight_ext;
      end
    end
  end

  assign o_pix_sum    = r_pix_sum;
  assign o_weight_sum = r_weight_sum;

endmodule

// File: rtl/nlm_accum_sched.sv
// Sequences one search window of (weight, pixel) taps through nlm_mac and
// holds the sums for the downstream divider until it accepts them.
module nlm_accum_sched
  import rawdns_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int SUM_WIDTH    = SUM_WIDTH_DEF,
  parameter int TAPS         = TAPS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic                    flush_i,
  input  logic                    tap_valid_i,
  output logic                    tap_ready_o,
  input  logic [WEIGHT_WIDTH-1:0] tap_weight_i,
  input  logic [DATA_WIDTH-1:0]   tap_pix_i,
  input  logic                    tap_last_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [SUM_WIDTH-1:0]    pix_sum_o,
  output logic [SUM_WIDTH-1:0]    weight_sum_o,
  output logic                    zero_w_o,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int                CNT_W    = cnt_width(TAPS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TAPS - 1);

  sched_state_t   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic           r_err;

  logic w_accept;
  logic w_first_tap;
  logic w_final_tap;
  logic w_frame_bad;

  assign w_accept    = (r_state == ST_ACCUM) && tap_valid_i && !flush_i;
  assign w_first_tap = (r_cnt == '0);
  assign w_final_tap = (r_cnt == LAST_CNT);
  // Last flag must be set exactly on the final tap; the window closes by count regardless.
  assign w_frame_bad = tap_last_i ^ w_final_tap;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (flush_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable_i) r_state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_err <= w_first_tap ? w_frame_bad : (r_err | w_frame_bad);
            if (w_final_tap) begin
              r_cnt   <= '0;
              r_state <= ST_HOLD;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready_i) r_state <= enable_i ? ST_ACCUM : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  nlm_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .SUM_WIDTH   (SUM_WIDTH)
  ) u_mac (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (flush_i),
    .i_en        (w_accept),
    .i_load      (w_first_tap),
    .i_weight    (tap_weight_i),
    .i_pix       (tap_pix_i),
    .o_pix_sum   (pix_sum_o),
    .o_weight_sum(weight_sum_o)
  );

  // Ready drops combinationally with flush so a coincident tap is never consumed.
  assign tap_ready_o  = (r_state == ST_ACCUM) && !flush_i;
  assign out_valid_o  = (r_state == ST_HOLD);
  assign busy_o       = (r_state != ST_IDLE);
  assign zero_w_o     = out_valid_o && (weight_sum_o == '0);
  assign err_o        = out_valid_o && r_err;

endmodule

// File: tb/tb_nlm_accum_sched.sv
// Directed bench for nlm_accum_sched: a 4-tap instance checked every cycle
// against a window-level model, plus a default 25-tap instance for the no-wrap case.
module tb_nlm_accum_sched;

  localparam int T4  = 4;
  localparam int T25 = 25;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        enable, flush, tvalid, tlast, out_ready;
  logic [7:0]  tw;
  logic [15:0] tp;
  logic        en25, v25, last25;

  logic        d4_ready, d4_valid, d4_zero, d4_err, d4_busy;
  logic [31:0] d4_pix, d4_ws;
  logic        d25_ready, d25_valid, d25_zero, d25_err, d25_busy;
  logic [31:0] d25_pix, d25_ws;

  nlm_accum_sched #(.TAPS(T4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .flush_i(flush),
    .tap_valid_i(tvalid), .tap_ready_o(d4_ready), .tap_weight_i(tw), .tap_pix_i(tp),
    .tap_last_i(tlast), .out_valid_o(d4_valid), .out_ready_i(out_ready),
    .pix_sum_o(d4_pix), .weight_sum_o(d4_ws), .zero_w_o(d4_zero),
    .err_o(d4_err), .busy_o(d4_busy)
  );

  nlm_accum_sched u_dut25 (
    .clk(clk), .rst_n(rst_n), .enable_i(en25), .flush_i(flush),
    .tap_valid_i(v25), .tap_ready_o(d25_ready), .tap_weight_i(tw), .tap_pix_i(tp),
    .tap_last_i(last25), .out_valid_o(d25_valid), .out_ready_i(out_ready),
    .pix_sum_o(d25_pix), .weight_sum_o(d25_ws), .zero_w_o(d25_zero),
    .err_o(d25_err), .busy_o(d25_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Window-level model of the 4-tap instance, evaluated between clock edges.
  int     cyc = 0;
  int     m_idx;
  longint m_ps, m_ws;
  bit     m_bad, m_hold;
  longint e_ps, e_ws;
  bit     e_err;
  int     res_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_idx = 0; m_ps = 0; m_ws = 0; m_bad = 0; m_hold = 0;
      e_ps = 0; e_ws = 0; e_err = 0;
    end else begin
      check("mon_valid", d4_valid, m_hold);
      if (m_hold) begin
        check("mon_pix_sum", d4_pix, e_ps[31:0]);
        check("mon_weight_sum", d4_ws, e_ws[31:0]);
        check("mon_zero_w", d4_zero, e_ws == 0);
        check("mon_err", d4_err, e_err);
        check("mon_ready_in_hold", d4_ready, 1'b0);
      end
      if (flush) check("mon_ready_in_flush", d4_ready, 1'b0);
      if (d4_valid && out_ready) res_cyc.push_back(cyc);
      if (flush) begin
        m_idx = 0; m_ps = 0; m_ws = 0; m_bad = 0; m_hold = 0;
      end else begin
        if (m_hold && out_ready) m_hold = 0;
        if (tvalid && d4_ready) begin
          m_ps  += longint'(tw) * longint'(tp);
          m_ws  += longint'(tw);
          m_bad |= (tlast != (m_idx == T4 - 1));
          m_idx++;
          if (m_idx == T4) begin
            e_ps = m_ps; e_ws = m_ws; e_err = m_bad; m_hold = 1;
            m_idx = 0; m_ps = 0; m_ws = 0; m_bad = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one tap to the 4-tap instance and return once it has been accepted.
  task automatic send4(input logic [7:0] w, input logic [15:0] p, input logic last);
    bit ok = 0;
    tw = w; tp = p; tlast = last; tvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (d4_ready) ok = 1;
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    check("tap_accepted_in_time", ok, 1'b1);
  endtask

  task automatic check_result4(input string tag, input logic [31:0] ps, input logic [31:0] ws,
                               input logic zero, input logic err);
    check({tag, "_valid"}, d4_valid, 1'b1);
    check({tag, "_pix_sum"}, d4_pix, ps);
    check({tag, "_weight_sum"}, d4_ws, ws);
    check({tag, "_zero_w"}, d4_zero, zero);
    check({tag, "_err"}, d4_err, err);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int idx, base, tgt, n25;
    bit dropped;
    rst_n = 1'b0; enable = 0; flush = 0; tvalid = 0; tlast = 0; out_ready = 0;
    tw = '0; tp = '0; en25 = 0; v25 = 0; last25 = 0;
    #12;
    check("rst_valid", d4_valid, 1'b0);
    check("rst_ready", d4_ready, 1'b0);
    check("rst_busy", d4_busy, 1'b0);
    check("rst_pix_sum", d4_pix, 32'd0);
    check("rst_weight_sum", d4_ws, 32'd0);
    check("rst_zero_w", d4_zero, 1'b0);
    check("rst_err", d4_err, 1'b0);
    check("rst25_busy", d25_busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic window.
    enable = 1; out_ready = 1;
    send4(8'd1, 16'd10, 0); send4(8'd2, 16'd20, 0);
    send4(8'd3, 16'd30, 0); send4(8'd4, 16'd40, 1);
    check_result4("basic", 32'd300, 32'd10, 1'b0, 1'b0);
    tick();

    // All-zero weights with a stalled consumer.
    out_ready = 0;
    for (int i = 0; i < 3; i++) send4(8'd0, 16'd7 + 16'(i), 0);
    send4(8'd0, 16'd99, 1);
    check_result4("zero_w", 32'd0, 32'd0, 1'b1, 1'b0);
    tw = 8'd1; tp = 16'd1; tlast = 0; tvalid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ready", d4_ready, 1'b0);
      check("stall_valid", d4_valid, 1'b1);
      check("stall_zero_w", d4_zero, 1'b1);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(negedge clk);
    check("handshake_cycle_ready", d4_ready, 1'b0);
    @(posedge clk); #1;
    tvalid = 0;
    @(negedge clk);
    check("after_handshake_ready", d4_ready, 1'b1);
    @(posedge clk); #1;

    // Framing error, then a clean window.
    send4(8'd1, 16'd1, 0); send4(8'd1, 16'd1, 1);
    send4(8'd1, 16'd1, 0); send4(8'd1, 16'd1, 0);
    check_result4("frame_err", 32'd4, 32'd4, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send4(8'd2, 16'd3, 0);
    send4(8'd2, 16'd3, 1);
    check_result4("frame_clean", 32'd24, 32'd8, 1'b0, 1'b0);

    // Flush after two taps, coincident with an offered tap.
    send4(8'd9, 16'd9, 0); send4(8'd9, 16'd9, 0);
    tw = 8'd7; tp = 16'd7; tlast = 0; tvalid = 1; flush = 1;
    @(negedge clk);
    check("flush_ready", d4_ready, 1'b0);
    @(posedge clk); #1;
    flush = 0; tvalid = 0;
    check("flush_busy", d4_busy, 1'b0);
    check("flush_valid", d4_valid, 1'b0);
    check("flush_pix_sum", d4_pix, 32'd0);
    for (int i = 0; i < 3; i++) send4(8'd1, 16'd5, 0);
    send4(8'd1, 16'd5, 1);
    check_result4("post_flush", 32'd20, 32'd4, 1'b0, 1'b0);

    // Back-to-back windows at full rate.
    idx = 0; tvalid = 1;
    base = res_cyc.size();
    for (int c = 0; c < 60 && res_cyc.size() < base + 4; c++) begin
      tw = 8'(idx + 1); tp = 16'(100 + idx); tlast = (idx == T4 - 1);
      @(negedge clk);
      if (d4_ready) idx = (idx + 1) % T4;
      @(posedge clk); #1;
    end
    check("b2b_results", res_cyc.size() >= base + 4, 1'b1);
    for (int k = 0; k < 3; k++)
      if (res_cyc.size() > base + k + 1)
        check("b2b_period", res_cyc[base + k + 1] - res_cyc[base + k], T4 + 1);

    // Drop enable mid-window: that window still completes, then IDLE.
    tgt = res_cyc.size() + 1; dropped = 0;
    for (int c = 0; c < 60 && res_cyc.size() < tgt; c++) begin
      tw = 8'(idx + 1); tp = 16'(100 + idx); tlast = (idx == T4 - 1);
      @(negedge clk);
      if (d4_ready) idx = (idx + 1) % T4;
      if (idx == 2 && !dropped) begin enable = 0; dropped = 1; end
      @(posedge clk); #1;
    end
    check("drop_en_delivered", res_cyc.size() >= tgt, 1'b1);
    check("drop_en_busy", d4_busy, 1'b0);
    @(negedge clk);
    check("drop_en_ready", d4_ready, 1'b0);
    @(posedge clk); #1;
    tvalid = 0;

    // Default geometry, full-scale taps: no wrap.
    en25 = 1; tw = 8'd255; tp = 16'hFFFF; v25 = 1; n25 = 0;
    for (int c = 0; c < 100 && n25 < T25; c++) begin
      last25 = (n25 == T25 - 1);
      @(negedge clk);
      if (d25_ready) n25++;
      @(posedge clk); #1;
    end
    v25 = 0; en25 = 0;
    check("full_scale_taps", n25, T25);
    check("full_scale_valid", d25_valid, 1'b1);
    check("full_scale_pix_sum", d25_pix, 32'd417785625);
    check("full_scale_weight_sum", d25_ws, 32'd6375);
    check("full_scale_zero_w", d25_zero, 1'b0);
    check("full_scale_err", d25_err, 1'b0);
    tick(); tick();
    check("full_scale_idle", d25_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nlm_accum_sched.md
Name: nlm_accum_sched

Overview:
- Sequences one search-window of (weight, search-pixel) taps per output pixel through a shared multiply-accumulate unit.
- Produces the weighted pixel sum and the weight sum for the downstream normaliser/divider.
- Sits between the weight generator and the divider in the RAWDNS denoise pipeline.
- Uses valid/ready on both sides and closes each window by tap count, with a framing check against tap_last_i.

Parameters:
- DATA_WIDTH, 16, search-pixel width (unsigned).
- WEIGHT_WIDTH, 8, weight width (unsigned).
- SUM_WIDTH, 32, width of both accumulators; must satisfy SUM_WIDTH >= DATA_WIDTH+WEIGHT_WIDTH+clog2(TAPS).
- TAPS, 25, taps per window (>= 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- enable_i  in  1  allow new windows to start
- flush_i  in  1  synchronous abort/clear
- tap_valid_i  in  1  tap offered
- tap_ready_o  out  1  tap accepted when valid&&ready
- tap_weight_i  in  WEIGHT_WIDTH  tap weight
- tap_pix_i  in  DATA_WIDTH  search pixel
- tap_last_i  in  1  upstream marks final tap of window
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts result
- pix_sum_o  out  SUM_WIDTH  sum of weight*pix over window
- weight_sum_o  out  SUM_WIDTH  sum of weights over window
- zero_w_o  out  1  weight_sum_o == 0 (qualified by out_valid_o)
- err_o  out  1  framing error in this window (qualified by out_valid_o)
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, tap count=0, both accumulators=0, err flag=0. All outputs 0.
- States:
  - IDLE: tap_ready_o=0. If enable_i, go to ACCUM next cycle.
  - ACCUM: tap_ready_o = !flush_i. Each accepted tap increments the count.
    - First tap (count 0) loads the accumulators: pix = w*p, wsum = w. There is no clear cycle.
    - Later taps add to the accumulators.
    - Accepting tap number TAPS moves to HOLD next cycle. Count resets to 0.
  - HOLD: out_valid_o=1, tap_ready_o=0. Sums, zero_w_o and err_o stay stable until out_ready_i.
    - On out_valid_o&&out_ready_i: go to ACCUM if enable_i, else IDLE.
    - The next tap is accepted no earlier than the cycle after the handshake.
- Latency: the result is visible on the cycle after the TAPS-th tap is accepted. Sustained throughput is TAPS+1 cycles per window when out_ready_i is held high.
- Arithmetic: unsigned multiply, product width DATA_WIDTH+WEIGHT_WIDTH, zero-extended to SUM_WIDTH. Accumulation wraps modulo 2^SUM_WIDTH with no saturation; the parameter rule guarantees no wrap occurs.
- Framing check:
  - err is set if tap_last_i=1 on any accepted tap other than the TAPS-th.
  - err is set if tap_last_i=0 on the TAPS-th tap.
  - The window still closes by count only.
  - err clears when the first tap of the next window loads.
- enable_i deasserted mid-window: the window completes normally; the block returns to IDLE after the output handshake.
- flush_i (any state): next state IDLE, count=0, accumulators=0, err=0, out_valid_o=0. A pending result is discarded. A tap offered in the same cycle is not accepted. flush_i has priority over everything except reset.
- Asynchronous reset mid-window: everything clears immediately; the partial window is lost.
- Pixel and weight inputs are ignored unless the tap is accepted.

Decomposition:
- Shared package rawdns_pkg holds:
  - state enum IDLE/ACCUM/HOLD;
  - default widths;
  - TAPS default 25 and the CNT_W = clog2(TAPS) localparam convention.
- One sub-module, nlm_mac: a registered multiply-accumulate pair with load/enable/clear inputs.
  - Same datapath role as the existing PE accumulate stage.
  - The FSM and counter stay in nlm_accum_sched.

Test Plan:
- TAPS=4; taps (w,p) = (1,10),(2,20),(3,30),(4,40), last on the 4th, out_ready=1 -> one cycle later out_valid=1, pix_sum=300, weight_sum=10, zero_w=0, err=0.
- Defaults, 25 taps of w=255, p=65535 -> pix_sum=417785625, weight_sum=6375, no wrap.
- TAPS=4, all weights 0 -> weight_sum=0, zero_w=1. Hold out_ready=0 for 5 cycles -> outputs stable, tap_ready=0 throughout, next window starts only after the handshake.
- TAPS=4, tap_last on the 2nd tap and not the 4th -> window closes after 4 taps with err=1. Following clean window -> err=0.
- TAPS=4, flush_i after 2 taps, coincident with a valid tap -> tap not accepted, busy drops next cycle. A new window of (1,5)x4 gives pix_sum=20, weight_sum=4, with no residue from the aborted window.
- Back-to-back windows with tap_valid and out_ready always high, enable high -> one result every TAPS+1 cycles. Drop enable mid-window -> current result is delivered, then the block enters IDLE.
